// File: rtl/l2_mem_responder.sv
// Unified 128-bit line store that serves the L2 I and D memory ports, with round-robin arbitration on ties.
// Latency: acceptance edge k gives a ready pulse in the cycle after edge k+LATENCY; one access runs at a time.
// Backpressure: requests are level-held until ready; the loser waits. L2_MEM_STAT_EN adds rd/wr counters.
module l2_mem_responder #(
  parameter int LATENCY = 4,
  parameter int IDX_W   = 8,
  parameter int LINE_W  = 128
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              Imem_read,
  input  logic              Imem_write,
  input  logic [27:0]       Imem_addr,
  input  logic [LINE_W-1:0] Imem_wdata,
  output logic              Imem_ready,
  output logic [LINE_W-1:0] Imem_rdata,
  input  logic              Dmem_read,
  input  logic              Dmem_write,
  input  logic [27:0]       Dmem_addr,
  input  logic [LINE_W-1:0] Dmem_wdata,
  output logic              Dmem_ready,
  output logic [LINE_W-1:0] Dmem_rdata
`ifdef L2_MEM_STAT_EN
  ,
  output logic [31:0]       stat_rd_cnt,
  output logic [31:0]       stat_wr_cnt
`endif
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic              port_d;
    logic              wr;
    logic [IDX_W-1:0]  idx;
    logic [LINE_W-1:0] wdata;
  } req_t;

  state_t            state, state_nxt;
  req_t              req;
  logic [CNT_W-1:0]  cnt;
  logic              prio_d;
  logic              mask_i, mask_d;
  logic              pend_i, pend_d;
  logic              grant, grant_d;
  logic              unused_addr_bits;
  logic [LINE_W-1:0] mem [0:(1<<IDX_W)-1];

  // Upper address bits alias onto the same line.
  assign unused_addr_bits = ^{Imem_addr[27:IDX_W], Dmem_addr[27:IDX_W]};

  assign pend_i  = (Imem_read | Imem_write) & ~mask_i;
  assign pend_d  = (Dmem_read | Dmem_write) & ~mask_d;
  assign grant   = (state == IDLE) & (pend_i | pend_d);
  assign grant_d = pend_d & (~pend_i | prio_d);

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend_i | pend_d) state_nxt = BUSY;
      BUSY:    if (cnt == '0)       state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Imem_ready = (state == DONE) & ~req.port_d;
    Dmem_ready = (state == DONE) &  req.port_d;
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      req    <= '0;
      cnt    <= '0;
      prio_d <= 1'b1;
      mask_i <= 1'b0;
      mask_d <= 1'b0;
    end else begin
      // The mask covers only the IDLE cycle after DONE, while the requester drops its held request.
      mask_i <= (state == DONE) & ~req.port_d;
      mask_d <= (state == DONE) &  req.port_d;
      if (grant) begin
        req.port_d <= grant_d;
        req.wr     <= grant_d ? Dmem_write : Imem_write;
        req.idx    <= grant_d ? Dmem_addr[IDX_W-1:0] : Imem_addr[IDX_W-1:0];
        req.wdata  <= grant_d ? Dmem_wdata : Imem_wdata;
        cnt        <= CNT_W'(LATENCY - 1);
        if (pend_i & pend_d) prio_d <= ~prio_d;
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      Imem_rdata <= '0;
      Dmem_rdata <= '0;
    end else if ((state == BUSY) && (cnt == '0) && !req.wr) begin
      if (req.port_d) Dmem_rdata <= mem[req.idx];
      else            Imem_rdata <= mem[req.idx];
    end
  end

  // Gated by the reset-cleared state, so an access aborted by reset never commits.
  always_ff @(posedge clk) begin
    if ((state == DONE) && req.wr) mem[req.idx] <= req.wdata;
  end

`ifdef L2_MEM_STAT_EN
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else if (state == DONE) begin
      if (req.wr) begin
        if (stat_wr_cnt != 32'hFFFF_FFFF) stat_wr_cnt <= stat_wr_cnt + 32'd1;
      end else begin
        if (stat_rd_cnt != 32'hFFFF_FFFF) stat_rd_cnt <= stat_rd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l2_mem_responder.sv
// Randomized bench for l2_mem_responder: a line-array reference model predicts each completion, and a monitor scoreboards them.
module tb_l2_mem_responder;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         proc_reset_n;
  logic         Imem_read, Imem_write, Dmem_read, Dmem_write;
  logic [27:0]  Imem_addr, Dmem_addr;
  logic [127:0] Imem_wdata, Dmem_wdata;
  logic         Imem_ready, Dmem_ready;
  logic [127:0] Imem_rdata, Dmem_rdata;
`ifdef L2_MEM_STAT_EN
  logic [31:0]  stat_rd_cnt, stat_wr_cnt;
`endif

  l2_mem_responder #(.LATENCY(LAT), .IDX_W(8), .LINE_W(128)) dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .Imem_read(Imem_read), .Imem_write(Imem_write), .Imem_addr(Imem_addr),
    .Imem_wdata(Imem_wdata), .Imem_ready(Imem_ready), .Imem_rdata(Imem_rdata),
    .Dmem_read(Dmem_read), .Dmem_write(Dmem_write), .Dmem_addr(Dmem_addr),
    .Dmem_wdata(Dmem_wdata), .Dmem_ready(Dmem_ready), .Dmem_rdata(Dmem_rdata)
`ifdef L2_MEM_STAT_EN
    , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
`endif
  );

  typedef struct {
    bit           port;   // 1 = D
    bit           is_rd;
    logic [127:0] rdata;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] mem_m [256];
  bit           prio_m;
  int           n_rd, n_wr, errors, checks, cyc, d_ready_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (Imem_ready === 1'b1 || Dmem_ready === 1'b1) begin
      if (Dmem_ready === 1'b1) d_ready_cnt++;
      chk("no_overlap", 128'(Imem_ready & Dmem_ready), 128'(0));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: I=%b D=%b at cycle %0d, required no ready", Imem_ready, Dmem_ready, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("ready_port", 128'(Dmem_ready), 128'(e.port));
        chk("ready_cycle", 128'(cyc), 128'(e.cyc));
        if (e.is_rd) chk("rdata", e.port ? Dmem_rdata : Imem_rdata, e.rdata);
      end
    end
  end

  // Reference model: one access in program order, write wins over read, index = low 8 address bits.
  function automatic void model(input bit p, input bit wr, input logic [27:0] a,
                                input logic [127:0] d, input int ecyc);
    exp_t e;
    int   idx;
    idx     = int'(a[7:0]);
    e.port  = p;
    e.is_rd = !wr;
    e.rdata = mem_m[idx];
    e.cyc   = ecyc;
    if (wr) begin
      mem_m[idx] = d;
      n_wr++;
    end else begin
      n_rd++;
    end
    exp_q.push_back(e);
  endfunction

  task automatic drive(input bit p, input bit rd, input bit wr, input logic [27:0] a,
                       input logic [127:0] d, input int hold);
    int n = 0;
    if (p) begin Dmem_read = rd; Dmem_write = wr; Dmem_addr = a; Dmem_wdata = d; end
    else   begin Imem_read = rd; Imem_write = wr; Imem_addr = a; Imem_wdata = d; end
    do begin
      @(negedge clk);
      n++;
    end while (!((p ? Dmem_ready : Imem_ready) === 1'b1) && n < 100);
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL ready_timeout: port %0d saw no ready within %0d cycles", p, n);
    end
    @(posedge clk); #1;
    repeat (hold) begin @(posedge clk); #1; end
    if (p) begin Dmem_read = 1'b0; Dmem_write = 1'b0; end
    else   begin Imem_read = 1'b0; Imem_write = 1'b0; end
  endtask

  task automatic single(input bit p, input bit rd, input bit wr, input logic [27:0] a,
                        input logic [127:0] d, input int hold);
    model(p, wr, a, d, cyc + 1 + LAT);
    drive(p, rd, wr, a, d, hold);
    @(posedge clk); #1;
  endtask

  task automatic pair(input bit rd_i, input bit wr_i, input logic [27:0] a_i, input logic [127:0] d_i,
                      input bit rd_d, input bit wr_d, input logic [27:0] a_d, input logic [127:0] d_d);
    int c;
    c = cyc;
    if (prio_m) begin
      model(1'b1, wr_d, a_d, d_d, c + 1 + LAT);
      model(1'b0, wr_i, a_i, d_i, c + 3 + 2 * LAT);
    end else begin
      model(1'b0, wr_i, a_i, d_i, c + 1 + LAT);
      model(1'b1, wr_d, a_d, d_d, c + 3 + 2 * LAT);
    end
    prio_m = !prio_m;
    fork
      drive(1'b0, rd_i, wr_i, a_i, d_i, 0);
      drive(1'b1, rd_d, wr_d, a_d, d_d, 0);
    join
    @(posedge clk); #1;
  endtask

  task automatic rand_op(output bit rd, output bit wr, output logic [27:0] a, output logic [127:0] d);
    int k;
    k  = $urandom_range(0, 2);
    rd = (k != 1);
    wr = (k != 0);
    a  = 28'($urandom);
    if ($urandom_range(0, 1) == 1) a[7:0] = 8'($urandom_range(0, 7));
    d  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  logic [127:0] old9, di, dd;
  logic [27:0]  ai, ad;
  bit           ri, wi, rd_d, wd;
  int           dcnt0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    Imem_read = 0; Imem_write = 0; Imem_addr = '0; Imem_wdata = '0;
    Dmem_read = 0; Dmem_write = 0; Dmem_addr = '0; Dmem_wdata = '0;
    proc_reset_n = 1'b0;
    prio_m = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_imem_ready", 128'(Imem_ready), 128'(0));
    chk("rst_dmem_ready", 128'(Dmem_ready), 128'(0));
    chk("rst_imem_rdata", Imem_rdata, 128'(0));
    chk("rst_dmem_rdata", Dmem_rdata, 128'(0));
    @(negedge clk) proc_reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++)
      single(i[0], 1'b0, 1'b1, 28'(i) | (28'($urandom) << 8), {$urandom, $urandom, $urandom, $urandom}, 0);

    single(1'b1, 1'b0, 1'b1, 28'h05, {16{8'hA5}}, 0);
    single(1'b0, 1'b1, 1'b0, 28'h105, '0, 0);

    pair(1'b1, 1'b0, 28'h10, '0, 1'b1, 1'b0, 28'h11, '0);

    dcnt0 = d_ready_cnt;
    single(1'b1, 1'b1, 1'b0, 28'h22, '0, 1);
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("hold_single_ready", 128'(d_ready_cnt - dcnt0), 128'(1));

    // Write to index 9 aborted by reset while BUSY.
    old9 = mem_m[9];
    Dmem_write = 1'b1; Dmem_addr = 28'h9; Dmem_wdata = {4{32'hDEADBEEF}};
    @(posedge clk); #1;
    @(posedge clk); #1;
    proc_reset_n = 1'b0;
    prio_m = 1'b1;
    n_rd = 0;
    n_wr = 0;
    #1;
    chk("busy_rst_imem_ready", 128'(Imem_ready), 128'(0));
    chk("busy_rst_dmem_ready", 128'(Dmem_ready), 128'(0));
    chk("busy_rst_imem_rdata", Imem_rdata, 128'(0));
    chk("busy_rst_dmem_rdata", Dmem_rdata, 128'(0));
    Dmem_write = 1'b0;
    @(posedge clk);
    @(negedge clk) proc_reset_n = 1'b1;
    @(posedge clk); #1;
    chk("model_idx9_unchanged", mem_m[9], old9);
    single(1'b1, 1'b1, 1'b0, 28'h9, '0, 0);
    single(1'b1, 1'b1, 1'b1, 28'h3, 128'h1, 0);
    single(1'b1, 1'b1, 1'b0, 28'h3, '0, 0);
    single(1'b0, 1'b0, 1'b1, 28'h20, {4{$urandom}}, 0);
    single(1'b1, 1'b0, 1'b1, 28'h21, {4{$urandom}}, 0);
`ifdef L2_MEM_STAT_EN
    chk("stat_wr_3", 128'(stat_wr_cnt), 128'(3));
    chk("stat_rd_2", 128'(stat_rd_cnt), 128'(2));
`endif

    for (int t = 0; t < 80; t++) begin
      rand_op(ri, wi, ai, di);
      if ($urandom_range(0, 3) == 0) begin
        rand_op(rd_d, wd, ad, dd);
        pair(ri, wi, ai, di, rd_d, wd, ad, dd);
      end else begin
        single(t[0], ri, wi, ai, di, 0);
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
`ifdef L2_MEM_STAT_EN
    chk("stat_wr_final", 128'(stat_wr_cnt), 128'(n_wr));
    chk("stat_rd_final", 128'(stat_rd_cnt), 128'(n_rd));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
